// File: rtl/deser_pkg.sv
// -----------------------------------------------------------------------------
// deser_pkg
// Shared definitions for the framed serial deserializer:
//   state_e         - framing state (HUNT waits for frame_start, SHIFT collects)
//   MSB_FIRST_MODE  - first received bit ends up in the MSB of the word
//   LSB_FIRST_MODE  - first received bit ends up in the LSB of the word
// -----------------------------------------------------------------------------
package deser_pkg;

  typedef enum logic {
    HUNT  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  localparam bit MSB_FIRST_MODE = 1'b0;
  localparam bit LSB_FIRST_MODE = 1'b1;

endpackage

// File: rtl/deser_out_stage.sv
// -----------------------------------------------------------------------------
// deser_out_stage
// Output holding register with valid/ready handshake and sticky overrun flag.
//   clk, reset    - clock, asynchronous active-high reset
//   word_done     - a complete word is presented on word_in this cycle
//   word_in       - the completed word
//   out_ready     - downstream accepts parallel_out while out_valid=1
//   overrun_clr   - clears the sticky overrun flag
//   parallel_out  - held word, stable until transferred
//   out_valid     - parallel_out holds an unaccepted word
//   overrun       - sticky: a completed word was dropped
// -----------------------------------------------------------------------------
module deser_out_stage #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             word_done,
  input  logic [WIDTH-1:0] word_in,
  input  logic             out_ready,
  input  logic             overrun_clr,
  output logic [WIDTH-1:0] parallel_out,
  output logic             out_valid,
  output logic             overrun
);

  logic transfer;
  logic can_load;
  logic drop;

  assign transfer = out_valid & out_ready;
  // The holding register is free if empty or being emptied on this very edge.
  assign can_load = ~out_valid | out_ready;
  assign drop     = word_done & ~can_load;

  // NOTE: state registers are updated with non-blocking assignments only, so
  // every flop samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      parallel_out <= '0;
      out_valid    <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      if (word_done && can_load) begin
        parallel_out <= word_in;
        out_valid    <= 1'b1;
      end else if (transfer) begin
        out_valid    <= 1'b0;
      end

      // A fresh drop wins over a clear requested on the same edge.
      if (drop) begin
        overrun <= 1'b1;
      end else if (overrun_clr) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/serial_deser_framed.sv
// -----------------------------------------------------------------------------
// serial_deser_framed
// Collects qualified serial bits into WIDTH-bit words. A frame_start marks
// bit 0 of a word; once framed, consecutive words follow without new
// frame_start pulses. Completed words go to a held output with valid/ready.
//   clk, reset    - clock, asynchronous active-high reset
//   serial_in     - serial data bit, used only when bit_valid=1
//   bit_valid     - qualifies serial_in this cycle
//   frame_start   - qualified bit is bit 0 of a new word
//   out_ready     - downstream accepts parallel_out
//   overrun_clr   - clears sticky overrun
//   parallel_out  - completed word
//   out_valid     - parallel_out holds an unaccepted word
//   overrun       - sticky: a completed word was dropped
//   bit_count     - bits accumulated in the current partial word
// Parameters: WIDTH (2..64), LSB_FIRST (0: first bit -> MSB, 1: first bit -> LSB)
// -----------------------------------------------------------------------------
module serial_deser_framed
  import deser_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter bit LSB_FIRST = MSB_FIRST_MODE
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       serial_in,
  input  logic                       bit_valid,
  input  logic                       frame_start,
  input  logic                       out_ready,
  input  logic                       overrun_clr,
  output logic [WIDTH-1:0]           parallel_out,
  output logic                       out_valid,
  output logic                       overrun,
  output logic [$clog2(WIDTH+1)-1:0] bit_count
);

  localparam int            CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [CW-1:0]    count_q, count_d;
  logic             word_done;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= HUNT;
      sreg_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      count_q <= count_d;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path through
  // the block leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    sreg_d    = sreg_q;
    count_d   = count_q;
    word_done = 1'b0;

    if (bit_valid) begin
      if (frame_start) begin
        // Restart from any state: the current bit is bit 0 of a new word.
        state_d   = SHIFT;
        sreg_d    = '0;
        sreg_d[0] = serial_in;
        count_d   = CW'(1);
      end else if (state_q == SHIFT) begin
        if (LSB_FIRST == LSB_FIRST_MODE) begin
          // Every position is rewritten once per word, so stale bits from
          // the previous word never leak into the next one.
          for (int i = 0; i < WIDTH; i++) begin
            if (count_q == CW'(i)) begin
              sreg_d[i] = serial_in;
            end
          end
        end else begin
          sreg_d = {sreg_q[WIDTH-2:0], serial_in};
        end

        if (count_q == LAST) begin
          word_done = 1'b1;
          count_d   = '0;
        end else begin
          count_d   = count_q + CW'(1);
        end
      end
    end
  end

  assign bit_count = count_q;

  // The word handed over is the register's next value, so the output is
  // loaded on the same edge that samples the last bit.
  deser_out_stage #(
    .WIDTH(WIDTH)
  ) u_out_stage (
    .clk         (clk),
    .reset       (reset),
    .word_done   (word_done),
    .word_in     (sreg_d),
    .out_ready   (out_ready),
    .overrun_clr (overrun_clr),
    .parallel_out(parallel_out),
    .out_valid   (out_valid),
    .overrun     (overrun)
  );

endmodule

// File: tb/tb_serial_deser_framed.sv
// -----------------------------------------------------------------------------
// tb_serial_deser_framed
// Two WIDTH=8 instances (MSB-first and LSB-first) share one stimulus stream
// and are compared against a queue-based reference model of the word framing
// and output handshake rules.
// -----------------------------------------------------------------------------
module tb_serial_deser_framed;

  localparam int W = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic       serial_in, bit_valid, frame_start, out_ready, overrun_clr;

  logic [7:0] po_m, po_l;
  logic       ov_m, ov_l, ovr_m, ovr_l;
  logic [3:0] bc_m, bc_l;

  logic [13:0] obs_m, obs_l;
  assign obs_m = {ov_m, ovr_m, bc_m, po_m};
  assign obs_l = {ov_l, ovr_l, bc_l, po_l};

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  serial_deser_framed #(.WIDTH(W), .LSB_FIRST(1'b0)) dut_msb (
    .clk(clk), .reset(reset), .serial_in(serial_in), .bit_valid(bit_valid),
    .frame_start(frame_start), .out_ready(out_ready), .overrun_clr(overrun_clr),
    .parallel_out(po_m), .out_valid(ov_m), .overrun(ovr_m), .bit_count(bc_m)
  );

  serial_deser_framed #(.WIDTH(W), .LSB_FIRST(1'b1)) dut_lsb (
    .clk(clk), .reset(reset), .serial_in(serial_in), .bit_valid(bit_valid),
    .frame_start(frame_start), .out_ready(out_ready), .overrun_clr(overrun_clr),
    .parallel_out(po_l), .out_valid(ov_l), .overrun(ovr_l), .bit_count(bc_l)
  );

  // ---------------- reference model ----------------
  bit         m_hunt;
  bit         m_bits[$];
  logic [7:0] m_out_m, m_out_l;
  bit         m_valid, m_ovr;

  function automatic logic [7:0] compose(input bit lsb);
    logic [7:0] w = '0;
    for (int i = 0; i < W; i++) begin
      if (lsb) w[i] = m_bits[i];
      else     w[W-1-i] = m_bits[i];
    end
    return w;
  endfunction

  function automatic logic [7:0] rev8(input logic [7:0] v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = v[7-i];
    return r;
  endfunction

  function automatic logic [13:0] exp_vec(input bit lsb);
    return {m_valid, m_ovr, 4'(m_bits.size()), (lsb ? m_out_l : m_out_m)};
  endfunction

  task automatic model_reset();
    m_hunt  = 1'b1;
    m_bits.delete();
    m_out_m = '0;
    m_out_l = '0;
    m_valid = 1'b0;
    m_ovr   = 1'b0;
  endtask

  // Drive one cycle, advance the model by that edge, settle 1 time unit.
  task automatic step(input bit bv, input bit fs, input bit si, input bit rdy,
                      input bit clr);
    bit         done = 1'b0;
    bit         drop;
    logic [7:0] wm = '0, wl = '0;
    bit_valid   = bv;
    frame_start = fs;
    serial_in   = si;
    out_ready   = rdy;
    overrun_clr = clr;
    @(posedge clk);
    if (bv) begin
      if (fs) begin
        m_bits.delete();
        m_bits.push_back(si);
        m_hunt = 1'b0;
      end else if (!m_hunt) begin
        m_bits.push_back(si);
        if (m_bits.size() == W) begin
          done = 1'b1;
          wm = compose(1'b0);
          wl = compose(1'b1);
          m_bits.delete();
        end
      end
    end
    drop = done && m_valid && !rdy;
    if (done && (!m_valid || rdy)) begin
      m_out_m = wm;
      m_out_l = wl;
      m_valid = 1'b1;
    end else if (m_valid && rdy) begin
      m_valid = 1'b0;
    end
    if (drop)     m_ovr = 1'b1;
    else if (clr) m_ovr = 1'b0;
    #1;
  endtask

  // Stream a word first-bit = w[7]; rdy_last applies to the final bit only.
  task automatic send_word(input logic [7:0] w, input bit fs, input bit rdy,
                           input bit rdy_last);
    for (int i = 7; i >= 0; i--)
      step(1'b1, fs && (i == 7), w[i], (i == 0) ? rdy_last : rdy, 1'b0);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    serial_in = 0; bit_valid = 0; frame_start = 0; out_ready = 0; overrun_clr = 0;
    model_reset();
    #12;
    n_vec++;
    if (obs_m !== 14'h0) begin
      n_err++; $display("FAIL reset_msb: got %h expected %h", obs_m, 14'h0);
    end
    n_vec++;
    if (obs_l !== 14'h0) begin
      n_err++; $display("FAIL reset_lsb: got %h expected %h", obs_l, 14'h0);
    end
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_stream(input logic [7:0] w, input logic [7:0] em,
                             input logic [7:0] el);
    send_word(w, 1'b1, 1'b1, 1'b1);
    n_vec++;
    if ({ov_m, ovr_m, po_m} !== {2'b10, em}) begin
      n_err++; $display("FAIL stream_msb_%h: got %h expected %h", w, {ov_m, ovr_m, po_m}, {2'b10, em});
    end
    n_vec++;
    if ({ov_l, ovr_l, po_l} !== {2'b10, el}) begin
      n_err++; $display("FAIL stream_lsb_%h: got %h expected %h", w, {ov_l, ovr_l, po_l}, {2'b10, el});
    end
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    n_vec++;
    if ({ov_m, ov_l} !== 2'b00) begin
      n_err++; $display("FAIL stream_pulse_%h: got %b expected 00", w, {ov_m, ov_l});
    end
  endtask

  task automatic test_overrun();
    logic [7:0] w1 = 8'h1E, w2 = 8'hB4;
    send_word(w1, 1'b1, 1'b0, 1'b0);
    n_vec++;
    if (obs_m !== {2'b10, 4'd0, w1} || obs_l !== {2'b10, 4'd0, rev8(w1)}) begin
      n_err++; $display("FAIL overrun_first: got %h/%h expected %h/%h", obs_m, obs_l,
                        {2'b10, 4'd0, w1}, {2'b10, 4'd0, rev8(w1)});
    end
    send_word(w2, 1'b0, 1'b0, 1'b0);
    n_vec++;
    if (obs_m !== {2'b11, 4'd0, w1} || obs_l !== {2'b11, 4'd0, rev8(w1)}) begin
      n_err++; $display("FAIL overrun_second: got %h/%h expected %h/%h", obs_m, obs_l,
                        {2'b11, 4'd0, w1}, {2'b11, 4'd0, rev8(w1)});
    end
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    n_vec++;
    if ({ov_m, ovr_m, ovr_l, po_m} !== {3'b100, w1}) begin
      n_err++; $display("FAIL overrun_clr: got %h expected %h", {ov_m, ovr_m, ovr_l, po_m}, {3'b100, w1});
    end
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    n_vec++;
    if ({ov_m, ov_l, ovr_m} !== 3'b000) begin
      n_err++; $display("FAIL overrun_transfer: got %b expected 000", {ov_m, ov_l, ovr_m});
    end
  endtask

  task automatic test_restart();
    for (int i = 0; i < 5; i++) step(1'b1, i == 0, 1'($urandom), 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    n_vec++;
    if ({bc_m, bc_l} !== 8'h11) begin
      n_err++; $display("FAIL restart_count: got %h expected 11", {bc_m, bc_l});
    end
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'($urandom), 1'b1, 1'b0);
    n_vec++;
    if (ov_m !== 1'b0) begin
      n_err++; $display("FAIL restart_early: got %b expected 0", ov_m);
    end
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    n_vec++;
    if (obs_m !== exp_vec(1'b0) || ov_m !== 1'b1 || ovr_m !== 1'b0) begin
      n_err++; $display("FAIL restart_done_msb: got %h expected %h", obs_m, exp_vec(1'b0));
    end
    n_vec++;
    if (obs_l !== exp_vec(1'b1) || po_l[0] !== 1'b1) begin
      n_err++; $display("FAIL restart_done_lsb: got %h expected %h", obs_l, exp_vec(1'b1));
    end
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 4; i++) step(1'b1, i == 0, 1'b1, 1'b1, 1'b0);
    #2 reset = 1'b1;
    #1;
    model_reset();
    n_vec++;
    if (obs_m !== 14'h0 || obs_l !== 14'h0) begin
      n_err++; $display("FAIL async_reset: got %h/%h expected 0/0", obs_m, obs_l);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    n_vec++;
    if ({bc_m, bc_l, ov_m, ov_l} !== 10'h0 || obs_m !== exp_vec(1'b0)) begin
      n_err++; $display("FAIL reset_hunt: got %h expected %h", obs_m, exp_vec(1'b0));
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] w1 = 8'h5A, w2 = 8'hC3;
    send_word(w1, 1'b1, 1'b0, 1'b0);
    send_word(w2, 1'b0, 1'b0, 1'b1);
    n_vec++;
    if (obs_m !== {2'b10, 4'd0, w2}) begin
      n_err++; $display("FAIL b2b_msb: got %h expected %h", obs_m, {2'b10, 4'd0, w2});
    end
    n_vec++;
    if (obs_l !== {2'b10, 4'd0, rev8(w2)}) begin
      n_err++; $display("FAIL b2b_lsb: got %h expected %h", obs_l, {2'b10, 4'd0, rev8(w2)});
    end
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_random();
    for (int c = 0; c < 2000; c++) begin
      step($urandom_range(3, 0) != 0, $urandom_range(19, 0) == 0, 1'($urandom),
           $urandom_range(9, 0) < 7, $urandom_range(9, 0) == 0);
      n_vec++;
      if (obs_m !== exp_vec(1'b0)) begin
        n_err++; $display("FAIL random_msb cyc %0d: got %h expected %h", c, obs_m, exp_vec(1'b0));
      end
      n_vec++;
      if (obs_l !== exp_vec(1'b1)) begin
        n_err++; $display("FAIL random_lsb cyc %0d: got %h expected %h", c, obs_l, exp_vec(1'b1));
      end
    end
  endtask

  initial begin
    test_reset();
    test_stream(8'hA5, 8'hA5, 8'hA5);
    test_stream(8'hC0, 8'hC0, 8'h03);
    test_overrun();
    test_restart();
    test_async_reset();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
